// File: rtl/arith_pkg.sv
// arith_pkg: shared states, mode encodings and sizing helper for the serial add/sub unit.
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/addsub_bit_cell.sv
// addsub_bit_cell: one-bit full subtractor / full adder selected by mode.
module addsub_bit_cell
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic chain_in,
  input  logic mode,
  output logic bit_out,
  output logic chain_out
);
  assign bit_out   = a ^ b ^ chain_in;
  assign chain_out = (mode == MODE_ADD) ? ((a & b) | (chain_in & (a ^ b)))
                                        : ((~a & b) | (~(a ^ b) & chain_in));
endmodule

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial LSB-first add/subtract with start/busy/done handshake and flags.
module serial_addsub_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int CW = clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0] bit_cnt;
  logic chain, mode_q, ovf_q, bit_out, chain_out, last;
  addsub_bit_cell u_cell (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .chain_in(chain),
    .mode(mode_q),
    .bit_out(bit_out),
    .chain_out(chain_out)
  );
  assign last = bit_cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  always_comb begin
    state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      bit_cnt    <= '0;
      chain      <= 1'b0;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state == DONE;
      case (state)
        IDLE: if (start) begin
          a_sh    <= operand_a;
          b_sh    <= operand_b;
          mode_q  <= mode;
          chain   <= borrow_in;
          bit_cnt <= '0;
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          r_sh    <= {bit_out, r_sh[WIDTH-1:1]};
          chain   <= chain_out;
          bit_cnt <= bit_cnt + 1'b1;
          // On the MSB step the cell inputs are the operand sign bits.
          if (last)
            ovf_q <= (mode_q == MODE_ADD) ? ((a_sh[0] == b_sh[0]) && (bit_out != a_sh[0]))
                                          : ((a_sh[0] != b_sh[0]) && (bit_out != a_sh[0]));
        end
        DONE: begin
          result     <= r_sh;
          borrow_out <= chain;
          overflow   <= ovf_q;
        end
        default: ;
      endcase
    end
  end
endmodule
